// File: rtl/mul_rs_if.sv
// Signal bundle between dispatch, the CDB, the multiplier and the multiply reservation station.
// The station connects through the slave modport; its environment drives the master side.
interface mul_rs_if #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [ROB_W-1:0] disp_rob;
    logic [3:0]       disp_aluop;
    logic             disp_a_val;
    logic             disp_b_val;
    logic [31:0]      disp_a;
    logic [31:0]      disp_b;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob;
    logic [31:0]      cdb_result;
    logic             fu_ready;
    logic             issue_valid;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [ROB_W-1:0] issue_rob;
    logic [3:0]       issue_aluop;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, disp_valid, disp_rob, disp_aluop, disp_a_val, disp_b_val,
               disp_a, disp_b, cdb_valid, cdb_rob, cdb_result, fu_ready,
        input  disp_ready, issue_valid, issue_a, issue_b, issue_rob, issue_aluop, count
    );

    modport slave (
        input  flush, disp_valid, disp_rob, disp_aluop, disp_a_val, disp_b_val,
               disp_a, disp_b, cdb_valid, cdb_rob, cdb_result, fu_ready,
        output disp_ready, issue_valid, issue_a, issue_b, issue_rob, issue_aluop, count
    );
endinterface

// File: rtl/mul_rs.sv
// Multiply reservation station: compacting queue (entry 0 oldest) with CDB operand capture
// and oldest-ready issue to the multiplier whenever it reports ready.
module mul_rs #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 4
) (
    input logic     clk,
    input logic     reset,
    mul_rs_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [3:0]       aluop;
        logic             a_rdy;
        logic [31:0]      a_data;
        logic             b_rdy;
        logic [31:0]      b_data;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woken [DEPTH+1];
    entry_t           disp_ent;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             disp_fire;
    logic             issue_fire;
    logic             a_byp;
    logic             b_byp;

    // True when an operand still waiting on a tag sees that tag on the CDB this cycle.
    function automatic logic tag_hit(input logic rdy, input logic [31:0] data,
                                     input logic cv, input logic [ROB_W-1:0] tag);
        return !rdy && cv && (data[ROB_W-1:0] == tag);
    endfunction

    // Select works on registered readiness only, so a same-cycle wakeup issues next cycle.
    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && (i < int'(count_q)) && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_fire      = bus.fu_ready && sel_found;
    assign disp_fire       = bus.disp_valid && bus.disp_ready;
    assign wr_idx          = count_q - CNT_W'(issue_fire);

    assign bus.disp_ready  = (int'(count_q) < DEPTH);
    assign bus.count       = count_q;
    assign bus.issue_valid = issue_fire;
    assign bus.issue_a     = sel_found ? ent_q[sel_idx].a_data : '0;
    assign bus.issue_b     = sel_found ? ent_q[sel_idx].b_data : '0;
    assign bus.issue_rob   = sel_found ? ent_q[sel_idx].rob    : '0;
    assign bus.issue_aluop = sel_found ? ent_q[sel_idx].aluop  : '0;

    // Incoming µop, with operands that appear on the CDB this very cycle captured directly.
    assign a_byp = tag_hit(bus.disp_a_val, bus.disp_a, bus.cdb_valid, bus.cdb_rob);
    assign b_byp = tag_hit(bus.disp_b_val, bus.disp_b, bus.cdb_valid, bus.cdb_rob);

    always_comb begin
        disp_ent        = '0;
        disp_ent.rob    = bus.disp_rob;
        disp_ent.aluop  = bus.disp_aluop;
        disp_ent.a_rdy  = bus.disp_a_val || a_byp;
        disp_ent.a_data = a_byp ? bus.cdb_result : bus.disp_a;
        disp_ent.b_rdy  = bus.disp_b_val || b_byp;
        disp_ent.b_data = b_byp ? bus.cdb_result : bus.disp_b;
    end

    // Wakeup view of the queue; the extra top slot feeds the shift when the last entry moves down.
    always_comb begin
        woken[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = ent_q[i];
            if (tag_hit(ent_q[i].a_rdy, ent_q[i].a_data, bus.cdb_valid, bus.cdb_rob)) begin
                woken[i].a_rdy  = 1'b1;
                woken[i].a_data = bus.cdb_result;
            end
            if (tag_hit(ent_q[i].b_rdy, ent_q[i].b_data, bus.cdb_valid, bus.cdb_rob)) begin
                woken[i].b_rdy  = 1'b1;
                woken[i].b_data = bus.cdb_result;
            end
        end
    end

    // Compaction: entries at and above the issued slot take their upper neighbour's woken state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (issue_fire && (i >= int'(sel_idx))) ? woken[i+1] : woken[i];
            if (disp_fire && (i == int'(wr_idx))) begin
                ent_d[i] = disp_ent;
            end
        end
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        if (bus.flush) begin
            count_d = '0;
        end
    end

    // Occupancy is the only validity state; flush and reset act on it alone.
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: the payload array has no reset; slots at or above count are never selected or shown.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_mul_rs.sv
// Directed self-checking bench for mul_rs: ordering, wakeup, bypass, full, busy, flush and reset.
module tb_mul_rs;
    localparam int DEPTH = 4;
    localparam int ROB_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    logic seen;

    always #5 clk = ~clk;

    mul_rs_if #(.DEPTH(DEPTH), .ROB_W(ROB_W)) bus ();

    mul_rs #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: signed 32x32 product, aluop bit0 picks the high word.
    function automatic logic [31:0] mul_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] op);
        logic signed [63:0] p;
        p = 64'($signed(a)) * 64'($signed(b));
        return op[0] ? p[63:32] : p[31:0];
    endfunction

    task automatic idle_inputs();
        bus.flush      = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_rob   = '0;
        bus.disp_aluop = '0;
        bus.disp_a_val = 1'b0;
        bus.disp_b_val = 1'b0;
        bus.disp_a     = '0;
        bus.disp_b     = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_rob    = '0;
        bus.cdb_result = '0;
    endtask

    task automatic disp(input logic [3:0] rob, input logic [3:0] op,
                        input logic av, input logic [31:0] a,
                        input logic bv, input logic [31:0] b);
        bus.disp_valid = 1'b1;
        bus.disp_rob   = rob;
        bus.disp_aluop = op;
        bus.disp_a_val = av;
        bus.disp_a     = a;
        bus.disp_b_val = bv;
        bus.disp_b     = b;
    endtask

    task automatic cdb(input logic [3:0] rob, input logic [31:0] res);
        bus.cdb_valid  = 1'b1;
        bus.cdb_rob    = rob;
        bus.cdb_result = res;
    endtask

    // Advance one edge; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        reset        = 1'b0;
        bus.fu_ready = 1'b0;
        idle_inputs();
        #3;
        check("rst_disp_ready", bus.disp_ready, 1);
        check("rst_issue_valid", bus.issue_valid, 0);
        check("rst_issue_a", bus.issue_a, 0);
        check("rst_issue_b", bus.issue_b, 0);
        check("rst_issue_rob", bus.issue_rob, 0);
        check("rst_issue_aluop", bus.issue_aluop, 0);
        check("rst_count", bus.count, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Back-to-back ready ops
        bus.fu_ready = 1'b1;
        disp(4'd2, 4'd0, 1'b1, 32'd7, 1'b1, 32'hFFFF_FFFD);
        #1;
        check("b2b_empty_issue", bus.issue_valid, 0);
        step();
        disp(4'd3, 4'd1, 1'b1, 32'h0001_0000, 1'b1, 32'h0001_0000);
        #1;
        check("b2b_issue0_valid", bus.issue_valid, 1);
        check("b2b_issue0_rob", bus.issue_rob, 2);
        check("b2b_issue0_result", mul_result(bus.issue_a, bus.issue_b, bus.issue_aluop), 32'hFFFF_FFEB);
        step();
        #1;
        check("b2b_issue1_valid", bus.issue_valid, 1);
        check("b2b_issue1_rob", bus.issue_rob, 3);
        check("b2b_issue1_aluop", bus.issue_aluop, 1);
        check("b2b_issue1_result", mul_result(bus.issue_a, bus.issue_b, bus.issue_aluop), 32'h0000_0001);
        step();
        #1;
        check("b2b_drained", bus.count, 0);

        // Wakeup and ordering
        disp(4'd5, 4'd0, 1'b1, 32'd3, 1'b0, 32'd9);
        #1;
        step();
        disp(4'd6, 4'd0, 1'b1, 32'd2, 1'b1, 32'd5);
        #1;
        check("wk_waiting_no_issue", bus.issue_valid, 0);
        check("wk_count1", bus.count, 1);
        step();
        cdb(4'd9, 32'd4);
        #1;
        check("wk_young_first_valid", bus.issue_valid, 1);
        check("wk_young_first_rob", bus.issue_rob, 6);
        step();
        #1;
        check("wk_old_valid", bus.issue_valid, 1);
        check("wk_old_rob", bus.issue_rob, 5);
        check("wk_old_b", bus.issue_b, 4);
        check("wk_old_a", bus.issue_a, 3);
        step();
        #1;
        check("wk_drained", bus.count, 0);

        // Dispatch-time bypass
        disp(4'd7, 4'd0, 1'b0, 32'd1, 1'b1, 32'd2);
        cdb(4'd1, 32'h55);
        #1;
        step();
        #1;
        check("byp_valid", bus.issue_valid, 1);
        check("byp_rob", bus.issue_rob, 7);
        check("byp_a", bus.issue_a, 32'h55);
        step();

        // Full station, then one issue with a wakeup riding the shift
        bus.fu_ready = 1'b0;
        disp(4'd10, 4'd0, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        disp(4'd11, 4'd0, 1'b0, 32'd12, 1'b1, 32'd2);
        step();
        disp(4'd12, 4'd0, 1'b1, 32'd3, 1'b1, 32'd4);
        step();
        disp(4'd13, 4'd0, 1'b1, 32'd5, 1'b1, 32'd6);
        step();
        #1;
        check("full_count", bus.count, 4);
        check("full_disp_ready", bus.disp_ready, 0);
        check("full_no_issue", bus.issue_valid, 0);
        disp(4'd14, 4'd0, 1'b1, 32'd9, 1'b1, 32'd9);
        step();
        #1;
        check("full_fifth_ignored", bus.count, 4);
        bus.fu_ready = 1'b1;
        disp(4'd14, 4'd0, 1'b1, 32'd9, 1'b1, 32'd9);
        cdb(4'd12, 32'h77);
        #1;
        check("full_issue_valid", bus.issue_valid, 1);
        check("full_issue_rob", bus.issue_rob, 10);
        check("full_refuse_same_cycle", bus.disp_ready, 0);
        step();
        bus.fu_ready = 1'b0;
        #1;
        check("full_after_count", bus.count, 3);
        check("full_after_ready", bus.disp_ready, 1);

        // Busy multiplier for 70 cycles
        seen = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (bus.issue_valid !== 1'b0) seen = 1'b1;
            step();
        end
        check("busy_no_issue", seen, 0);
        check("busy_count_held", bus.count, 3);
        bus.fu_ready = 1'b1;
        #1;
        check("busy_rel0_rob", bus.issue_rob, 11);
        check("busy_rel0_a", bus.issue_a, 32'h77);
        step();
        #1;
        check("busy_rel1_rob", bus.issue_rob, 12);
        step();
        #1;
        check("busy_rel2_rob", bus.issue_rob, 13);
        check("busy_rel2_b", bus.issue_b, 6);
        step();
        #1;
        check("busy_drained", bus.count, 0);

        // Flush
        bus.fu_ready = 1'b0;
        disp(4'd1, 4'd0, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        disp(4'd2, 4'd0, 1'b1, 32'd2, 1'b1, 32'd2);
        step();
        disp(4'd3, 4'd0, 1'b1, 32'd3, 1'b1, 32'd3);
        step();
        #1;
        check("flush_pre_count", bus.count, 3);
        bus.flush = 1'b1;
        disp(4'd4, 4'd0, 1'b1, 32'd4, 1'b1, 32'd4);
        step();
        #1;
        check("flush_count", bus.count, 0);
        bus.fu_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.issue_valid !== 1'b0) seen = 1'b1;
            step();
        end
        check("flush_no_stale_issue", seen, 0);

        // Asynchronous reset mid-cycle
        bus.fu_ready = 1'b0;
        disp(4'd8, 4'd0, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        disp(4'd9, 4'd0, 1'b1, 32'd1, 1'b1, 32'd1);
        step();
        bus.fu_ready = 1'b1;
        #1;
        check("arst_pre_issue", bus.issue_valid, 1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_issue_valid", bus.issue_valid, 0);
        check("arst_issue_rob", bus.issue_rob, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        disp(4'd15, 4'd2, 1'b1, 32'd6, 1'b1, 32'd7);
        #1;
        check("arst_empty_no_issue", bus.issue_valid, 0);
        step();
        #1;
        check("arst_first_valid", bus.issue_valid, 1);
        check("arst_first_rob", bus.issue_rob, 15);
        check("arst_first_result", mul_result(bus.issue_a, bus.issue_b, bus.issue_aluop), 32'd42);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mul_rs.md
# mul_rs

Reservation station for the integer multiply functional unit, sitting between dispatch and the multiplier in the execute stage. It buffers up to DEPTH multiply µops and captures missing source operands by snooping the common data bus. It issues the oldest fully-ready µop to the multiplier whenever the multiplier reports ready.

## Interface
- DEPTH, 4: number of entries, 2..8.
- ROB_W, 4: ROB tag width, covering 16 ROB entries.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all entries immediately.
- flush  in  1  synchronous squash; invalidates all entries at the next edge.
- disp_valid  in  1  a dispatch µop is presented.
- disp_ready  out  1  space available; high when count < DEPTH.
- disp_rob  in  ROB_W  destination ROB tag of the µop.
- disp_aluop  in  4  multiply op; bit0 = 1 selects the high product word.
- disp_a_val, disp_b_val  in  1 each  the operand value is already present.
- disp_a, disp_b  in  32 each  operand value if present, otherwise the producer's ROB tag in bits [ROB_W-1:0].
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rob  in  ROB_W  tag of the broadcast result.
- cdb_result  in  32  broadcast value.
- fu_ready  in  1  the multiplier is idle and accepts an operation this cycle.
- issue_valid  out  1  an operation is presented to the multiplier; doubles as its start strobe.
- issue_a, issue_b  out  32 each  operands (A = multiplier, B = multiplicand).
- issue_rob  out  ROB_W  ROB tag of the issued µop.
- issue_aluop  out  4  op of the issued µop.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- **Storage is a compacting queue.**
  - Entry 0 is the oldest.
  - Each entry holds: valid, rob, aluop, and per operand (a_rdy, a_data).
  - While a_rdy = 0, a_data[ROB_W-1:0] holds the awaited tag.
- **Dispatch fires** when disp_valid & disp_ready.
  - The µop is written at index count, or at count-1 if an issue fires in the same cycle.
- **Dispatch-time bypass.** If an operand is not present and cdb_valid with cdb_rob equal to that operand's tag in the same cycle, the operand is stored with a_rdy = 1 and data = cdb_result.
- **Wakeup.** Each cycle, every valid entry whose operand has rdy = 0 and tag == cdb_rob while cdb_valid captures cdb_result and sets rdy = 1. All matching entries and operands wake in parallel.
- **Select.** The lowest-index valid entry with both operands ready.
  - Readiness is taken from registered state only. An operand woken this cycle is eligible next cycle.
- **Issue.**
  - issue_valid = fu_ready & (a selected entry exists).
  - issue_* carry the selected entry's fields whenever a selected entry exists, and are 0 otherwise.
  - At the edge where issue_valid = 1, the entry is removed. Higher entries shift down by one, and a wakeup applied in that cycle moves along with its entry.
- **No issue without fu_ready.** issue_valid never asserts while fu_ready = 0. The multiplier latches its tag and op on any start strobe, so a strobe while it is busy would corrupt an in-flight operation.
- **Count update.** count' = count + dispatch_fire - issue_fire.
  - disp_ready depends only on registered count. A full station refuses dispatch even when an issue fires that same cycle.
- **flush** has priority over dispatch, wakeup and issue. The next state is empty (count = 0).
  - issue_valid may still be high during the flush cycle. The multiplier's result is then squashed by the ROB, not here.
- **reset low** forces every entry invalid and count = 0 asynchronously. The station accepts dispatch on the first edge after reset returns high.

## Timing
- Reset values:
  - disp_ready = 1
  - issue_valid = 0
  - issue_a, issue_b, issue_rob, issue_aluop = 0
  - count = 0
- Minimum latency: a µop dispatched with both operands present at edge N can issue in cycle N+1, i.e. it is removed at edge N+1, provided fu_ready = 1.
- Wakeup latency: a CDB broadcast in cycle N makes the waiting entry eligible in cycle N+1.
- Throughput is bounded by the multiplier. fu_ready drops for about 66 cycles per operation, and the station holds its contents throughout.
- Simultaneous dispatch, wakeup and issue all complete in one edge without loss or duplication.

## Test plan
- **Back-to-back ready ops.**
  - Stimulus: dispatch A=7, B=-3 (rob 2, aluop 0), then A=0x10000, B=0x10000 (rob 3, aluop 1), both operands present, fu_ready = 1.
  - Required: the issues appear in order (rob 2 then rob 3), each one cycle after its dispatch.
  - Expected multiplier results: 0xFFFFFFEB and 0x00000001.
- **Wakeup and ordering.**
  - Stimulus: dispatch rob 5 awaiting tag 9 on B, then rob 6 with both operands present. Broadcast cdb_rob=9, result=4 two cycles later.
  - Required: rob 6 issues first; rob 5 issues with issue_b = 4 in the cycle after the broadcast.
- **Dispatch-time bypass.**
  - Stimulus: dispatch awaiting tag 1 on A while cdb_valid, cdb_rob = 1, result = 0x55 in the same cycle.
  - Required: the entry issues next cycle with issue_a = 0x55.
- **Full station.**
  - Stimulus: fill 4 entries with fu_ready = 0.
  - Required: disp_ready = 0 and a fifth disp_valid is ignored (count stays 4).
  - Then raise fu_ready for one cycle: exactly one issue of entry 0, count goes to 3, disp_ready returns to 1.
- **Busy multiplier.** Hold fu_ready = 0 for 70 cycles with ready entries -> issue_valid stays 0 throughout and no entry is lost.
- **Flush and reset.**
  - Stimulus: flush with 3 entries.
  - Required: count = 0 next cycle, and no later issue carries the flushed tags.
  - Stimulus: assert reset low mid-cycle.
  - Required: count = 0 and issue_valid = 0 without waiting for a clock edge.
